// File: rtl/wr_nic_pkg.sv
// Shared types and constants for the WR NIC upstream Wishbone master.
//   wbm_state_t     : master FSM state encoding (IDLE, BUS, RESP)
//   WBM_TIMEOUT_DEF : default bus-cycle timeout in clock cycles
//   RSP_ERR_DATA    : fill bit for rsp_dat on writes and errored commands
package wr_nic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_t;

    localparam int   WBM_TIMEOUT_DEF = 255;
    localparam logic RSP_ERR_DATA    = 1'b0;

endpackage

// File: rtl/wr_nic_wb_timeout.sv
// Bus-cycle watchdog for wr_nic_wb_master.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : zero the per-cycle counter (held while the master is idle)
//   enable      : count one cycle (asserted while a bus cycle is open)
//   cancel      : slave terminated the cycle this edge, so a terminal count is not a timeout
//   tc          : terminal count, high during the TIMEOUT-th cycle of an open bus cycle
//   timeout_cnt : saturating count of bus cycles aborted by timeout
module wr_nic_wb_timeout
    import wr_nic_pkg::*;
#(
    parameter int TIMEOUT = WBM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        cancel,
    output logic        tc,
    output logic [15:0] timeout_cnt
);

    logic [15:0] tmo;

    // tmo holds the number of BUS cycles already completed, so the cycle in which
    // it equals TIMEOUT-1 is the last one stb may stay high.
    assign tc = enable && (tmo == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo         <= '0;
            timeout_cnt <= '0;
        end else begin
            if (clear) begin
                tmo <= '0;
            end else if (enable) begin
                tmo <= tmo + 16'd1;
            end
            if (tc && !cancel && (timeout_cnt != 16'hFFFF)) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/wr_nic_wb_master.sv
// Upstream Wishbone master: turns valid/ready register commands into single
// classic Wishbone cycles and returns one response per command.
//   clk_125m, rst                     : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready               : command handshake
//   cmd_we/adr/dat/sel                : command fields, latched on acceptance
//   rsp_valid/rsp_ready               : response handshake
//   rsp_dat/rsp_err                   : read data (0 on writes/errors), error flag
//   wb_cyc_o .. wb_sel_o              : registered Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_err_i      : Wishbone slave returns
//   timeout_cnt                       : saturating count of timed-out cycles
//   dbg_state                         : current FSM state for observation
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the producer holds valid and its payload stable until that edge, and a
// held response is never changed while rsp_valid is high and rsp_ready is low.
module wr_nic_wb_master
    import wr_nic_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = WBM_TIMEOUT_DEF
) (
    input  logic                clk_125m,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_err,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    output logic [15:0]         timeout_cnt,
    output logic [1:0]          dbg_state
);

    wbm_state_t state;
    logic       tmo_tc;

    // Gated by rst so the port reads 0 while reset is held.
    assign cmd_ready = (state == IDLE) && !rst;
    assign dbg_state = state;

    wr_nic_wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk         (clk_125m),
        .rst         (rst),
        .clear       (state == IDLE),
        .enable      (state == BUS),
        .cancel      (wb_ack_i || wb_err_i),
        .tc          (tmo_tc),
        .timeout_cnt (timeout_cnt)
    );

    always_ff @(posedge clk_125m or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wb_we_o  <= cmd_we;
                        wb_adr_o <= cmd_adr;
                        wb_dat_o <= cmd_dat;
                        wb_sel_o <= cmd_sel;
                        if (cmd_adr[1:0] != 2'b00) begin
                            // Misaligned: answer with an error, never touch the bus.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_dat   <= {DATA_W{RSP_ERR_DATA}};
                            state     <= RESP;
                        end else begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            state    <= BUS;
                        end
                    end
                end
                BUS: begin
                    // err has priority over a simultaneous ack.
                    if (wb_err_i || (!wb_ack_i && tmo_tc)) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_dat   <= {DATA_W{RSP_ERR_DATA}};
                        state     <= RESP;
                    end else if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_dat   <= wb_we_o ? {DATA_W{RSP_ERR_DATA}} : wb_dat_i;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    wb_cyc_o  <= 1'b0;
                    wb_stb_o  <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
